// File: rtl/lcd_hex_writer.sv
// HD44780-style LCD writer: prints a latched hex value, a space and "OK"/"ER".
// Optional controller init prefix is enabled by defining LCD_INIT_SEQ_EN.
module lcd_hex_writer #(
    parameter int NIBBLES        = 8,
    parameter int SETUP_CYC      = 2,
    parameter int EN_CYC         = 4,
    parameter int WAIT_CYC       = 8,
    parameter int CLEAR_WAIT_CYC = 100
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] value,
    input  logic                 erro,
    output logic                 busy,
    output logic                 done,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic                 LCD_EN,
    output logic [7:0]           LCD_DATA
);

    localparam int HOLD_MAX = (WAIT_CYC > CLEAR_WAIT_CYC) ? WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int SE_MAX   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int CNT_MAX  = (HOLD_MAX > SE_MAX) ? HOLD_MAX : SE_MAX;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int IW       = 5;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        widx;
    logic [2:0]           pre_q, pre_acc;
    logic [4*NIBBLES-1:0] val_q;
    logic                 err_q;
    logic                 acc, is_clear, hold_end, last_wr;
    int                   cnt_i, hold_tgt;

    // Returns {RS, DATA} for write index w of a sequence with a pre-length command prefix.
    function automatic logic [8:0] sel_byte(input logic [IW-1:0] w, input logic [2:0] pre,
                                            input logic [4*NIBBLES-1:0] v, input logic e);
        int         k;
        logic [3:0] nib;
        k        = int'(w) - int'(pre);
        sel_byte = {1'b1, 8'h20};
        if (k < 0) begin
            if (pre == 3'd1) sel_byte = {1'b0, 8'h01};
            else begin
                case (w)
                    5'd0:    sel_byte = {1'b0, 8'h38};
                    5'd1:    sel_byte = {1'b0, 8'h0C};
                    5'd2:    sel_byte = {1'b0, 8'h06};
                    default: sel_byte = {1'b0, 8'h01};
                endcase
            end
        end else if (k < NIBBLES) begin
            nib      = 4'(v >> (4 * (NIBBLES - 1 - k)));
            sel_byte = {1'b1, (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib})};
        end else if (k == NIBBLES + 1) begin
            sel_byte = {1'b1, e ? 8'h45 : 8'h4F};
        end else if (k == NIBBLES + 2) begin
            sel_byte = {1'b1, e ? 8'h52 : 8'h4B};
        end
    endfunction

`ifdef LCD_INIT_SEQ_EN
    logic init_done;
    assign pre_acc = init_done ? 3'd1 : 3'd4;
`else
    assign pre_acc = 3'd0;
`endif

    // The load step is folded into the transition that enters SETUP.
    assign acc      = start && (state == S_IDLE || state == S_DONE);
    assign is_clear = !LCD_RS && (LCD_DATA == 8'h01);
    assign cnt_i    = int'(cnt);
    assign hold_tgt = is_clear ? CLEAR_WAIT_CYC : WAIT_CYC;
    assign hold_end = (state == S_HOLD) && (cnt_i >= hold_tgt - 1);
    assign last_wr  = int'(widx) == int'(pre_q) + NIBBLES + 2;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (acc) state_nx = S_SETUP;
            S_SETUP: if (cnt_i >= SETUP_CYC - 1) state_nx = S_PULSE;
            S_PULSE: if (cnt_i >= EN_CYC - 1) state_nx = S_HOLD;
            S_HOLD:  if (hold_end) state_nx = last_wr ? S_DONE : S_SETUP;
            S_DONE:  state_nx = acc ? S_SETUP : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == S_SETUP) || (state == S_PULSE) || (state == S_HOLD);
        done   = (state == S_DONE);
        LCD_EN = (state == S_PULSE);
        LCD_RW = 1'b0;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt      <= '0;
            widx     <= '0;
            pre_q    <= '0;
            val_q    <= '0;
            err_q    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
        end else begin
            cnt <= (state_nx != state) ? '0 : ((cnt == '1) ? cnt : cnt + 1'b1);
            if (acc) begin
                val_q              <= value;
                err_q              <= erro;
                pre_q              <= pre_acc;
                widx               <= '0;
                {LCD_RS, LCD_DATA} <= sel_byte('0, pre_acc, value, erro);
            end else if (hold_end && !last_wr) begin
                widx               <= widx + 1'b1;
                {LCD_RS, LCD_DATA} <= sel_byte(widx + 1'b1, pre_q, val_q, err_q);
            end
        end
    end

`ifdef LCD_INIT_SEQ_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)                  init_done <= 1'b0;
        else if (hold_end && is_clear) init_done <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Directed bench for lcd_hex_writer: default instance (8 digits) and a small 4-digit instance.
module tb_lcd_hex_writer;
    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    always #5 Clock = ~Clock;

`ifdef LCD_INIT_SEQ_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic        a_start, a_erro, a_busy, a_done, a_rs, a_rw, a_en;
    logic [31:0] a_value;
    logic [7:0]  a_data;
    logic        b_start, b_erro, b_busy, b_done, b_rs, b_rw, b_en;
    logic [15:0] b_value;
    logic [7:0]  b_data;

    lcd_hex_writer u_a (
        .Clock(Clock), .Reset_n(Reset_n), .start(a_start), .value(a_value), .erro(a_erro),
        .busy(a_busy), .done(a_done), .LCD_RS(a_rs), .LCD_RW(a_rw), .LCD_EN(a_en), .LCD_DATA(a_data)
    );

    lcd_hex_writer #(.NIBBLES(4), .SETUP_CYC(1), .EN_CYC(2), .WAIT_CYC(3), .CLEAR_WAIT_CYC(5)) u_b (
        .Clock(Clock), .Reset_n(Reset_n), .start(b_start), .value(b_value), .erro(b_erro),
        .busy(b_busy), .done(b_done), .LCD_RS(b_rs), .LCD_RW(b_rw), .LCD_EN(b_en), .LCD_DATA(b_data)
    );

    int         n_chk = 0, n_fail = 0, edge_cnt = 0;
    logic [8:0] qa[$], qb[$], exp_q[$];
    int         wa[$], ga[$];
    int         a_done_n = 0, b_done_n = 0, a_done_cyc = 0, b_done_cyc = 0, a_acc = 0, b_acc = 0;
    int         a_w = 0, a_fall = 0;
    logic       a_en_q = 1'b0, b_en_q = 1'b0;

    // Samples 1 time unit after each rising edge; cycle numbers count the accept edge as 0.
    always @(posedge Clock) begin
        edge_cnt++;
        #1;
        if (a_en && !a_en_q) begin qa.push_back({a_rs, a_data}); ga.push_back(edge_cnt - a_fall); a_w = 0; end
        if (a_en) a_w++;
        if (!a_en && a_en_q) begin wa.push_back(a_w); a_fall = edge_cnt; end
        a_en_q = a_en;
        if (a_done) begin a_done_n++; a_done_cyc = edge_cnt - a_acc + 1; end
        if (b_en && !b_en_q) qb.push_back({b_rs, b_data});
        b_en_q = b_en;
        if (b_done) begin b_done_n++; b_done_cyc = edge_cnt - b_acc + 1; end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [8:0] pfx(input int pre, input int i);
        if (pre == 1) return 9'h001;
        case (i)
            0:       return 9'h038;
            1:       return 9'h00C;
            2:       return 9'h006;
            default: return 9'h001;
        endcase
    endfunction

    task automatic cmp_q(input string tag, input bit use_b, input int pre);
        logic [8:0] got[$];
        if (use_b) got = qb; else got = qa;
        chk({tag, "_count"}, got.size(), pre + exp_q.size());
        if (got.size() == pre + exp_q.size()) begin
            for (int i = 0; i < pre; i++) chk({tag, "_cmd"}, got[i], pfx(pre, i));
            for (int i = 0; i < exp_q.size(); i++) chk({tag, "_chr"}, got[pre + i], exp_q[i]);
        end
    endtask

    // EN width is 4; low gap between strobes is WAIT+SETUP, or CLEAR_WAIT+SETUP after 0x01.
    task automatic chk_timing_a(input string tag);
        chk({tag, "_nwidth"}, wa.size(), qa.size());
        foreach (wa[i]) chk({tag, "_enw"}, wa[i], 4);
        for (int i = 1; i < ga.size(); i++)
            chk({tag, "_gap"}, ga[i], (qa[i-1] == 9'h001) ? 102 : 10);
    endtask

    task automatic go_a(input logic [31:0] v, input logic e);
        qa.delete(); wa.delete(); ga.delete();
        a_value = v; a_erro = e; a_start = 1'b1; a_acc = edge_cnt + 1;
        @(negedge Clock);
        a_start = 1'b0;
    endtask

    task automatic wait_a(input string tag, input int tgt);
        int t = 0;
        while (a_done_n < tgt && t < 3000) begin @(negedge Clock); t++; end
        chk({tag, "_done_seen"}, a_done_n, tgt);
    endtask

    task automatic wait_b(input string tag, input int tgt);
        int t = 0;
        while (b_done_n < tgt && t < 3000) begin @(negedge Clock); t++; end
        chk({tag, "_done_seen"}, b_done_n, tgt);
    endtask

    int pre, tgt, d, n0;

    initial begin
        a_start = 0; a_value = '0; a_erro = 0;
        b_start = 0; b_value = '0; b_erro = 0;
        repeat (3) @(negedge Clock);
        chk("rst_a", {a_busy, a_done, a_rs, a_rw, a_en, a_data}, 0);
        chk("rst_b", {b_busy, b_done, b_rs, b_rw, b_en, b_data}, 0);
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            chk("idle_a", {a_busy, a_done, a_rs, a_rw, a_en, a_data}, 0);
            chk("idle_b", {b_busy, b_done, b_rs, b_rw, b_en, b_data}, 0);
        end

        // DEADBEEF / OK, first sequence after reset
        pre = INIT_EN ? 4 : 0;
        exp_q = '{9'h144, 9'h145, 9'h141, 9'h144, 9'h142, 9'h145, 9'h145, 9'h146, 9'h120, 9'h14F, 9'h14B};
        tgt = a_done_n + 1;
        go_a(32'hDEADBEEF, 1'b0);
        chk("a1_busy_c1", a_busy, 1);
        chk("a1_en_c1", a_en, 0);
        chk("a1_first", {a_rs, a_data}, (pre > 0) ? pfx(pre, 0) : exp_q[0]);
        wait_a("a1", tgt);
        chk("a1_done_cyc", a_done_cyc, INIT_EN ? 303 : 155);
        chk("a1_done_busy", {a_done, a_busy}, 2'b10);
        @(negedge Clock);
        chk("a1_after", {a_done, a_busy}, 2'b00);
        cmp_q("a1", 1'b0, pre);
        chk_timing_a("a1");

        // Second sequence: 01234567 / ER
        pre = INIT_EN ? 1 : 0;
        exp_q = '{9'h130, 9'h131, 9'h132, 9'h133, 9'h134, 9'h135, 9'h136, 9'h137, 9'h120, 9'h145, 9'h152};
        tgt = a_done_n + 1;
        go_a(32'h01234567, 1'b1);
        wait_a("a2", tgt);
        chk("a2_done_cyc", a_done_cyc, INIT_EN ? 261 : 155);
        cmp_q("a2", 1'b0, pre);
        chk_timing_a("a2");

        // Small instance: 00A9 / ER, inputs changed mid-sequence
        pre = INIT_EN ? 4 : 0;
        exp_q = '{9'h130, 9'h130, 9'h141, 9'h139, 9'h120, 9'h145, 9'h152};
        qb.delete();
        tgt = b_done_n + 1;
        b_value = 16'h00A9; b_erro = 1'b1; b_start = 1'b1; b_acc = edge_cnt + 1;
        @(negedge Clock);
        b_start = 1'b0;
        chk("b_busy_c1", b_busy, 1);
        repeat (10) @(negedge Clock);
        b_value = 16'hFFFF; b_erro = 1'b0;
        wait_b("b", tgt);
        chk("b_done_cyc", b_done_cyc, INIT_EN ? 69 : 43);
        cmp_q("b", 1'b1, pre);

        // Start held high: re-accept in the done cycle, one accept per sequence
        pre = INIT_EN ? 1 : 0;
        qa.delete(); wa.delete(); ga.delete();
        a_value = 32'hDEADBEEF; a_erro = 1'b0; a_start = 1'b1; a_acc = edge_cnt + 1;
        tgt = a_done_n + 1;
        wait_a("c1", tgt);
        d = a_done_cyc;
        chk("c1_done_cyc", d, INIT_EN ? 261 : 155);
        @(negedge Clock);
        chk("c_reacc_busy", {a_busy, a_en}, 2'b10);
        chk("c_reacc_byte", {a_rs, a_data}, INIT_EN ? 9'h001 : 9'h144);
        a_start = 1'b0;
        wait_a("c2", tgt + 1);
        chk("c2_done_cyc", a_done_cyc, d + (INIT_EN ? 261 : 155));
        chk("c_nbytes", qa.size(), 2 * (pre + 11));
        repeat (20) @(negedge Clock);
        chk("c_no_extra", a_done_n, tgt + 1);
        chk("c_idle", a_busy, 0);

        // Reset during PULSE of the third digit
        pre = INIT_EN ? 1 : 0;
        go_a(32'hDEADBEEF, 1'b0);
        for (int t = 0; t < 500 && qa.size() < pre + 3; t++) @(negedge Clock);
        chk("r_reach_d3", qa.size(), pre + 3);
        chk("r_en_before", a_en, 1);
        #2 Reset_n = 1'b0;
        #1 chk("r_async", {a_busy, a_done, a_rs, a_rw, a_en, a_data}, 0);
        n0 = a_done_n;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (200) @(negedge Clock);
        chk("r_no_done", a_done_n, n0);
        chk("r_idle", {a_busy, a_en}, 0);

        pre = INIT_EN ? 4 : 0;
        exp_q = '{9'h146, 9'h146, 9'h146, 9'h146, 9'h130, 9'h130, 9'h130, 9'h130, 9'h120, 9'h14F, 9'h14B};
        tgt = a_done_n + 1;
        go_a(32'hFFFF0000, 1'b0);
        wait_a("r2", tgt);
        chk("r2_done_cyc", a_done_cyc, INIT_EN ? 303 : 155);
        cmp_q("r2", 1'b0, pre);
        chk_timing_a("r2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
